// File: rtl/iob_fifo_wptr_ctrl_pkg.sv
// Shared definitions for the dual-clock FIFO pointer controllers.
// Holds the default geometry and width-generic Gray/binary conversion helpers.
// The helpers work at MAX_W bits: zero-extend narrower values, then truncate the result.
package iob_fifo_wptr_ctrl_pkg;

    localparam int unsigned ADDR_W_DFLT = 4;
    localparam int unsigned PTR_W_DFLT  = ADDR_W_DFLT + 1;
    localparam int unsigned DEPTH_DFLT  = 1 << ADDR_W_DFLT;
    localparam int unsigned MAX_W       = 17;

    // Binary to reflected Gray code.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    // Zero upper bits leave the running XOR at 0, so any width up to MAX_W works.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        logic             acc;
        b   = '0;
        acc = 1'b0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

endpackage

// File: rtl/iob_gray2bin.sv
// Combinational Gray-to-binary converter, shared by the write and read pointer controllers.
// Ports: gray_i (W-bit Gray code in), bin_o (W-bit binary out).
module iob_gray2bin
    import iob_fifo_wptr_ctrl_pkg::*;
#(
    parameter int unsigned W = PTR_W_DFLT
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    assign bin_o = W'(gray2bin(MAX_W'(gray_i)));

endmodule

// File: rtl/iob_fifo_wptr_ctrl.sv
// Write-side pointer controller for a dual-clock FIFO, entirely in the write domain.
// Ports: clk_i/cke_i/rst_n_i (clock, enable, sync active-low reset); w_en_i push request;
// r_ptr_gray_i synchronized read Gray pointer; ovf_clr_i clears sticky overflow;
// w_mem_en_o RAM write strobe (combinational); w_addr_o RAM address; w_ptr_gray_o Gray
// write pointer to the read domain; w_full_o, w_level_o, w_overflow_o registered status.
module iob_fifo_wptr_ctrl
    import iob_fifo_wptr_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DFLT
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              rst_n_i,
    input  logic              w_en_i,
    input  logic [ADDR_W:0]   r_ptr_gray_i,
    input  logic              ovf_clr_i,
    output logic              w_mem_en_o,
    output logic [ADDR_W-1:0] w_addr_o,
    output logic [ADDR_W:0]   w_ptr_gray_o,
    output logic              w_full_o,
    output logic [ADDR_W:0]   w_level_o,
    output logic              w_overflow_o
);

    localparam int unsigned PTR_W = ADDR_W + 1;
    // Full when write Gray equals read Gray with its top two bits inverted.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);

    logic [PTR_W-1:0] wbin_q, wbin_d;
    logic [PTR_W-1:0] wgray_q, wgray_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic [PTR_W-1:0] rbin;
    logic             accept;

    iob_gray2bin #(
        .W (PTR_W)
    ) u_rptr_g2b (
        .gray_i (r_ptr_gray_i),
        .bin_o  (rbin)
    );

    // Push acceptance and next pointer/status values.
    always_comb begin
        accept  = w_en_i & ~full_q & cke_i & rst_n_i;
        wbin_d  = wbin_q + PTR_W'(accept);
        wgray_d = PTR_W'(bin2gray(MAX_W'(wbin_d)));
        full_d  = (wgray_d == (r_ptr_gray_i ^ FULL_MASK));
        level_d = wbin_d - rbin;
        // Set wins over clear.
        ovf_d   = (w_en_i & full_q) | (ovf_q & ~ovf_clr_i);
    end

    // Enabled register bank; reset overrides the clock enable.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (cke_i) begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            level_q <= level_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
        end
    end

    assign w_mem_en_o   = accept;
    assign w_addr_o     = wbin_q[ADDR_W-1:0];
    assign w_ptr_gray_o = wgray_q;
    assign w_full_o     = full_q;
    assign w_level_o    = level_q;
    assign w_overflow_o = ovf_q;

endmodule

// File: tb/tb_iob_fifo_wptr_ctrl.sv
// Self-checking bench for iob_fifo_wptr_ctrl at ADDR_W=2: directed vector table
// followed by randomized traffic checked against an occupancy-count model.
module tb_iob_fifo_wptr_ctrl;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned NVEC   = 24;

    logic              clk;
    logic              cke;
    logic              rst_n;
    logic              w_en;
    logic [PTR_W-1:0]  r_ptr_gray;
    logic              ovf_clr;
    logic              w_mem_en;
    logic [ADDR_W-1:0] w_addr;
    logic [PTR_W-1:0]  w_ptr_gray;
    logic              w_full;
    logic [PTR_W-1:0]  w_level;
    logic              w_overflow;

    int checks = 0;
    int errors = 0;

    iob_fifo_wptr_ctrl #(
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_i        (clk),
        .cke_i        (cke),
        .rst_n_i      (rst_n),
        .w_en_i       (w_en),
        .r_ptr_gray_i (r_ptr_gray),
        .ovf_clr_i    (ovf_clr),
        .w_mem_en_o   (w_mem_en),
        .w_addr_o     (w_addr),
        .w_ptr_gray_o (w_ptr_gray),
        .w_full_o     (w_full),
        .w_level_o    (w_level),
        .w_overflow_o (w_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst_n;
        logic             cke;
        logic             en;
        logic [PTR_W-1:0] rg;
        logic             clr;
        logic             mem;   // strobe expected before the edge
        logic [1:0]       addr;  // registered values expected after the edge
        logic [2:0]       gray;
        logic             full;
        logic [2:0]       level;
        logic             ovf;
    } vec_t;

    vec_t vecs [NVEC];

    // Reference model in terms of push/pop counts.
    int  m_wcnt, m_rcnt;
    bit  m_full, m_ovf;
    int  m_level;

    function automatic logic [2:0] to_gray(input int n);
        logic [2:0] b;
        b = 3'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp, input int idx);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit c, input bit e, input bit cl);
        bit acc;
        bit full_old;
        acc      = r & c & e & ~m_full;
        full_old = m_full;
        if (!r) begin
            m_wcnt = 0; m_rcnt = 0; m_full = 0; m_ovf = 0; m_level = 0;
        end else if (c) begin
            m_wcnt  = m_wcnt + int'(acc);
            m_level = m_wcnt - m_rcnt;
            m_full  = (m_level == DEPTH);
            m_ovf   = (e & full_old) | (m_ovf & ~cl);
        end
    endtask

    task automatic apply_vec(input int i);
        rst_n = vecs[i].rst_n; cke = vecs[i].cke; w_en = vecs[i].en;
        r_ptr_gray = vecs[i].rg; ovf_clr = vecs[i].clr;
        #4;
        check("mem_en", int'(w_mem_en), int'(vecs[i].mem), i);
        @(posedge clk);
        #1;
        check("addr",  int'(w_addr),     int'(vecs[i].addr),  i);
        check("gray",  int'(w_ptr_gray), int'(vecs[i].gray),  i);
        check("full",  int'(w_full),     int'(vecs[i].full),  i);
        check("level", int'(w_level),    int'(vecs[i].level), i);
        check("ovf",   int'(w_overflow), int'(vecs[i].ovf),   i);
    endtask

    task automatic rand_step(input int i);
        bit r, c, e, cl, exp_acc;
        r  = ($urandom_range(39) != 0);
        c  = ($urandom_range(99) < 85);
        e  = ($urandom_range(99) < 60);
        cl = ($urandom_range(99) < 10);
        if (!r) m_rcnt = 0;
        else if (m_rcnt < m_wcnt && $urandom_range(99) < 40) m_rcnt++;
        rst_n = r; cke = c; w_en = e; ovf_clr = cl;
        r_ptr_gray = to_gray(m_rcnt);
        exp_acc = r & c & e & ~m_full;
        #4;
        check("rnd_mem_en", int'(w_mem_en), int'(exp_acc), i);
        if (exp_acc)
            check("rnd_waddr", int'(w_addr), m_wcnt % DEPTH, i);
        @(posedge clk);
        model_edge(r, c, e, cl);
        #1;
        check("rnd_addr",  int'(w_addr),     m_wcnt % DEPTH,          i);
        check("rnd_gray",  int'(w_ptr_gray), int'(to_gray(m_wcnt)),   i);
        check("rnd_full",  int'(w_full),     int'(m_full),            i);
        check("rnd_level", int'(w_level),    m_level,                 i);
        check("rnd_ovf",   int'(w_overflow), int'(m_ovf),             i);
    endtask

    initial begin
        // rst cke en rg clr | mem addr gray full level ovf
        // reset with push held
        vecs[0]  = '{0,1,1,3'b000,0, 0,0,3'b000,0,0,0};
        vecs[1]  = '{0,1,1,3'b000,0, 0,0,3'b000,0,0,0};
        // fill to full, then overflow
        vecs[2]  = '{1,1,1,3'b000,0, 1,1,3'b001,0,1,0};
        vecs[3]  = '{1,1,1,3'b000,0, 1,2,3'b011,0,2,0};
        vecs[4]  = '{1,1,1,3'b000,0, 1,3,3'b010,0,3,0};
        vecs[5]  = '{1,1,1,3'b000,0, 1,0,3'b110,1,4,0};
        vecs[6]  = '{1,1,1,3'b000,0, 0,0,3'b110,1,4,1};
        // drain one and wrap
        vecs[7]  = '{1,1,0,3'b001,0, 0,0,3'b110,0,3,1};
        vecs[8]  = '{1,1,1,3'b001,0, 1,1,3'b111,1,4,1};
        // push while read pointer leaves full: rejected, then accepted
        vecs[9]  = '{1,1,1,3'b011,0, 0,1,3'b111,0,3,1};
        vecs[10] = '{1,1,1,3'b011,0, 1,2,3'b101,1,4,1};
        // clear with rejected push: set wins; then clear alone
        vecs[11] = '{1,1,1,3'b011,1, 0,2,3'b101,1,4,1};
        vecs[12] = '{1,1,0,3'b011,1, 0,2,3'b101,1,4,0};
        // drain to level 2, then freeze with cke low
        vecs[13] = '{1,1,0,3'b010,0, 0,2,3'b101,0,3,0};
        vecs[14] = '{1,1,0,3'b110,0, 0,2,3'b101,0,2,0};
        vecs[15] = '{1,0,1,3'b110,0, 0,2,3'b101,0,2,0};
        vecs[16] = '{1,0,1,3'b110,1, 0,2,3'b101,0,2,0};
        vecs[17] = '{1,0,1,3'b111,0, 0,2,3'b101,0,2,0};
        vecs[18] = '{1,1,1,3'b110,0, 1,3,3'b100,0,3,0};
        // refill, overflow, drain to level 3, then mid-operation reset
        vecs[19] = '{1,1,1,3'b110,0, 1,0,3'b000,1,4,0};
        vecs[20] = '{1,1,1,3'b110,0, 0,0,3'b000,1,4,1};
        vecs[21] = '{1,1,0,3'b111,0, 0,0,3'b000,0,3,1};
        vecs[22] = '{0,1,1,3'b000,0, 0,0,3'b000,0,0,0};
        vecs[23] = '{1,1,1,3'b000,0, 1,1,3'b001,0,1,0};

        rst_n = 1'b0; cke = 1'b1; w_en = 1'b0; r_ptr_gray = '0; ovf_clr = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NVEC); i++) apply_vec(i);

        // Address seen with the strobe right after the post-reset push is the wrapped slot 1.
        w_en = 1'b1; rst_n = 1'b1; cke = 1'b1; r_ptr_gray = 3'b000; ovf_clr = 1'b0;
        #4;
        check("post_rst_addr", int'(w_addr), 1, 0);
        check("post_rst_mem",  int'(w_mem_en), 1, 0);
        @(posedge clk);
        #1;

        // Synchronize model with a reset, then random traffic.
        rst_n = 1'b0; w_en = 1'b0; r_ptr_gray = '0;
        @(posedge clk);
        model_edge(1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        for (int i = 0; i < 400; i++) rand_step(i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
